// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : N-way round-robin arbiter. Grants one requester at a time and
//             holds the grant until the owner drops its request. Priority
//             rotates so that the last owner is lowest priority next time.
//             Optional macro RR_ARB_TIMEOUT_EN caps a grant at MAX_HOLD
//             cycles and pulses 'timeout' on the forced release.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  r,
    output logic [N-1:0]  g,
    output logic          g_valid,
    output logic [IW-1:0] g_idx,
    output logic          timeout
);

    // Reject out-of-range configurations at elaboration time.
    if ((N < 2) || (N > 16) || (MAX_HOLD < 1) || (MAX_HOLD > 65535)) begin : g_bad_params
        $error("rr_arbiter: N must be 2..16 and MAX_HOLD 1..65535");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [N-1:0]  g_q,     g_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          valid_q, valid_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] next_ptr;

`ifdef RR_ARB_TIMEOUT_EN
    logic [15:0]   hold_q,  hold_d;
    logic          to_q,    to_d;
`endif

    // Circular first-set search of r starting at ptr.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!win_found && r[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Pointer value after the current owner releases: (owner + 1) mod N.
    assign next_ptr = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                g_d     = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                if (win_found) begin
                    g_d[win_idx] = 1'b1;
                    idx_d        = win_idx;
                    valid_d      = 1'b1;
                    state_d      = S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d       = '0;
`endif
                end
            end
            S_GRANT: begin
                if (!r[idx_q]) begin
                    g_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_q == 16'(MAX_HOLD - 1)) begin
                    // Owner still requesting but its time is up: preempt.
                    g_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end else begin
                    hold_d  = hold_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign g       = g_q;
    assign g_valid = valid_q;
    assign g_idx   = idx_q;

endmodule
`default_nettype wire
